// File: rtl/instr_prefetch.sv
// Instruction prefetch: reads aligned word pairs from the RAM port and queues {pc, instr}
// entries in a small FIFO toward decode, with branch redirect and port stealing via mem_gnt.
module instr_prefetch #(
  parameter int AW       = 10,
  parameter int DW       = 10,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [AW-1:0]   redirect_pc,
  input  logic            mem_gnt,
  output logic [AW-1:0]   mem_addr,
  input  logic [2*DW-1:0] mem_rdata,
  output logic            instr_valid,
  output logic [DW-1:0]   instr,
  output logic [AW-1:0]   instr_pc,
  input  logic            instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  logic [EW-1:0] fifo_q [DEPTH];
  logic [EW-1:0] fifo_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;

  logic [CW-1:0] free;
  logic          pop;
  logic          push_pair;
  logic          push_one;
  logic [DW-1:0] word_lo;
  logic [DW-1:0] word_hi;
  logic [EW-1:0] head;
  logic          not_empty;

  assign word_lo   = mem_rdata[DW-1:0];
  assign word_hi   = mem_rdata[2*DW-1:DW];
  assign not_empty = (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  assign mem_addr    = fetch_pc_q;
  assign instr_valid = not_empty && !redirect;
  assign instr       = not_empty ? head[DW-1:0]     : '0;
  assign instr_pc    = not_empty ? head[EW-1:DW]    : '0;

  // Free space uses the pre-pop count, so a slot freed by a pop is only reusable next cycle.
  assign free      = CW'(DEPTH) - count_q;
  assign pop       = instr_valid && instr_ready;
  assign push_pair = mem_gnt && !redirect && !fetch_pc_q[0] && (free >= CW'(2));
  assign push_one  = mem_gnt && !redirect && !push_pair && (free >= CW'(1));

  always_comb begin
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (push_pair) begin
        fifo_d[wr_ptr_q]            = {fetch_pc_q, word_lo};
        fifo_d[wr_ptr_q + PW'(1)]   = {fetch_pc_q + AW'(1), word_hi};
        wr_ptr_d                    = wr_ptr_q + PW'(2);
        fetch_pc_d                  = fetch_pc_q + AW'(2);
      end else if (push_one) begin
        // Odd pc takes the high half of the pair; even pc with one free slot takes the low half.
        fifo_d[wr_ptr_q] = {fetch_pc_q, fetch_pc_q[0] ? word_hi : word_lo};
        wr_ptr_d         = wr_ptr_q + PW'(1);
        fetch_pc_d       = fetch_pc_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (push_pair ? CW'(2) : (push_one ? CW'(1) : CW'(0)))
                        - (pop ? CW'(1) : CW'(0));
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          fifo_q[gi] <= '0;
        end else begin
          fifo_q[gi] <= fifo_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= AW'(RESET_PC);
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

endmodule
